// File: rtl/mem_txn_fsm.sv
// Runs one flash transaction at a time on a byte-level QSPI engine: READ, or WREN -> PROG -> RDSR polling.
// Data paths are combinational pass-throughs with valid/ready; define MEM_TXN_TIMEOUT_EN to bound polling and raise sticky err.
module mem_txn_fsm #(
  parameter int         ADDR_W        = 24,
  parameter int         LEN_W         = 9,
  parameter logic [7:0] RD_OPCODE     = 8'h6B,
  parameter logic [7:0] PP_OPCODE     = 8'h32,
  parameter logic [7:0] WREN_OPCODE   = 8'h06,
  parameter logic [7:0] RDSR_OPCODE   = 8'h05,
  parameter int         RD_DUMMY      = 8,
  parameter int         TIMEOUT_POLLS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              r_w,
  input  logic              address_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic              length_valid,
  input  logic [LEN_W-1:0]  length,
  input  logic [7:0]        in_fsm_data,
  input  logic              in_fsm_valid,
  input  logic              in_fsm_ready,
  output logic [7:0]        out_fsm_data,
  output logic              out_fsm_valid,
  output logic              out_fsm_ready,
  output logic              txn_done,
  output logic              err,
  output logic              qspi_start,
  output logic [7:0]        qspi_cmd,
  output logic              qspi_addr_en,
  output logic [ADDR_W-1:0] qspi_addr,
  output logic [3:0]        qspi_dummy,
  output logic              qspi_rw,
  output logic [LEN_W-1:0]  qspi_len,
  input  logic              qspi_done,
  output logic [7:0]        qspi_tx_data,
  output logic              qspi_tx_valid,
  input  logic              qspi_tx_ready,
  input  logic [7:0]        qspi_rx_data,
  input  logic              qspi_rx_valid,
  output logic              qspi_rx_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WREN, S_PROG, S_POLL, S_DONE
  } state_t;

  typedef struct packed {
    logic [7:0]        op;
    logic              addr_en;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        dummy;
    logic              rw;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  localparam logic [3:0] RD_DUMMY_C = 4'(RD_DUMMY);

  state_t            state_q;
  cmd_t              cmd_q;
  logic              start_q;
  logic              txn_done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic              addr_pend_q;
  logic              len_pend_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_d;
  logic              done_seen_q;
  logic              wip_q;
  logic              wip_d;
  logic              rx_hs;
  logic              tx_hs;

`ifdef MEM_TXN_TIMEOUT_EN
  localparam int            PCW      = $clog2(TIMEOUT_POLLS + 1);
  localparam logic [PCW-1:0] POLL_MAX = PCW'(TIMEOUT_POLLS);
  logic [PCW-1:0] poll_cnt_q;
  logic           err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  function automatic cmd_t mk_cmd(input logic [7:0]        op,
                                  input logic              addr_en,
                                  input logic [ADDR_W-1:0] addr,
                                  input logic [3:0]        dummy,
                                  input logic              rw,
                                  input logic [LEN_W-1:0]  len);
    cmd_t c;
    c.op      = op;
    c.addr_en = addr_en;
    c.addr    = addr;
    c.dummy   = dummy;
    c.rw      = rw;
    c.len     = len;
    return c;
  endfunction

  assign qspi_start    = start_q;
  assign qspi_cmd      = cmd_q.op;
  assign qspi_addr_en  = cmd_q.addr_en;
  assign qspi_addr     = cmd_q.addr;
  assign qspi_dummy    = cmd_q.dummy;
  assign qspi_rw       = cmd_q.rw;
  assign qspi_len      = cmd_q.len;
  assign txn_done      = txn_done_q;

  assign out_fsm_data  = (state_q == S_READ) ? qspi_rx_data : 8'h00;
  assign out_fsm_valid = (state_q == S_READ) && qspi_rx_valid;
  assign qspi_rx_ready = (state_q == S_READ) ? in_fsm_ready : (state_q == S_POLL);
  assign qspi_tx_data  = (state_q == S_PROG) ? in_fsm_data : 8'h00;
  assign qspi_tx_valid = (state_q == S_PROG) && in_fsm_valid;
  assign out_fsm_ready = (state_q == S_IDLE) || ((state_q == S_PROG) && qspi_tx_ready);

  always_comb begin
    rx_hs = qspi_rx_valid && qspi_rx_ready;
    tx_hs = qspi_tx_valid && qspi_tx_ready;
    cnt_d = cnt_q;
    if (((state_q == S_READ) && rx_hs) || ((state_q == S_PROG) && tx_hs)) begin
      cnt_d = cnt_q + 1'b1;
    end
    // A status byte arriving with qspi_done must decide that same cycle.
    wip_d = ((state_q == S_POLL) && rx_hs) ? qspi_rx_data[0] : wip_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      start_q     <= 1'b0;
      txn_done_q  <= 1'b1;
      addr_q      <= '0;
      len_q       <= '0;
      addr_pend_q <= 1'b0;
      len_pend_q  <= 1'b0;
      cnt_q       <= '0;
      done_seen_q <= 1'b0;
      wip_q       <= 1'b0;
`ifdef MEM_TXN_TIMEOUT_EN
      poll_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      cnt_q   <= cnt_d;
      wip_q   <= wip_d;
      unique case (state_q)
        S_IDLE: begin
          if (ena && addr_pend_q && len_pend_q) begin
            addr_pend_q <= 1'b0;
            len_pend_q  <= 1'b0;
            txn_done_q  <= 1'b0;
            cnt_q       <= '0;
            done_seen_q <= 1'b0;
            if (len_q == '0) begin
              state_q <= S_DONE;
            end else if (r_w) begin
              state_q <= S_READ;
              start_q <= 1'b1;
              cmd_q   <= mk_cmd(RD_OPCODE, 1'b1, addr_q, RD_DUMMY_C, 1'b1, len_q);
            end else begin
              state_q <= S_WREN;
              start_q <= 1'b1;
              cmd_q   <= mk_cmd(WREN_OPCODE, 1'b0, addr_q, 4'd0, 1'b0, '0);
            end
          end else begin
            if (address_valid) begin
              addr_q      <= address;
              addr_pend_q <= 1'b1;
            end
            if (length_valid) begin
              len_q      <= length;
              len_pend_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          // qspi_done may lead the final handshakes under backpressure; remember it.
          if (qspi_done || done_seen_q) begin
            if (cnt_d == len_q) begin
              state_q <= S_DONE;
            end else begin
              done_seen_q <= 1'b1;
            end
          end
        end
        S_WREN: begin
          if (qspi_done) begin
            state_q <= S_PROG;
            start_q <= 1'b1;
            cmd_q   <= mk_cmd(PP_OPCODE, 1'b1, addr_q, 4'd0, 1'b0, len_q);
          end
        end
        S_PROG: begin
          if (qspi_done) begin
            state_q <= S_POLL;
            start_q <= 1'b1;
            wip_q   <= 1'b0;
            cmd_q   <= mk_cmd(RDSR_OPCODE, 1'b0, addr_q, 4'd0, 1'b1, LEN_W'(1));
`ifdef MEM_TXN_TIMEOUT_EN
            poll_cnt_q <= PCW'(1);
`endif
          end
        end
        S_POLL: begin
          if (qspi_done) begin
            if (wip_d) begin
`ifdef MEM_TXN_TIMEOUT_EN
              if (poll_cnt_q >= POLL_MAX) begin
                err_q   <= 1'b1;
                state_q <= S_DONE;
              end else begin
                start_q    <= 1'b1;
                wip_q      <= 1'b0;
                poll_cnt_q <= poll_cnt_q + 1'b1;
              end
`else
              start_q <= 1'b1;
              wip_q   <= 1'b0;
`endif
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          txn_done_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_txn_fsm.sv
// Directed bench for mem_txn_fsm: table of transactions run against a scripted QSPI responder, plus corner sequences.
module tb_mem_txn_fsm;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        r_w;
  logic        address_valid;
  logic [23:0] address;
  logic        length_valid;
  logic [8:0]  length;
  logic [7:0]  in_fsm_data;
  logic        in_fsm_valid;
  logic        in_fsm_ready;
  logic [7:0]  out_fsm_data;
  logic        out_fsm_valid;
  logic        out_fsm_ready;
  logic        txn_done;
  logic        err;
  logic        qspi_start;
  logic [7:0]  qspi_cmd;
  logic        qspi_addr_en;
  logic [23:0] qspi_addr;
  logic [3:0]  qspi_dummy;
  logic        qspi_rw;
  logic [8:0]  qspi_len;
  logic        qspi_done;
  logic [7:0]  qspi_tx_data;
  logic        qspi_tx_valid;
  logic        qspi_tx_ready;
  logic [7:0]  qspi_rx_data;
  logic        qspi_rx_valid;
  logic        qspi_rx_ready;

`ifdef MEM_TXN_TIMEOUT_EN
  localparam int TB_POLLS = 4;
`else
  localparam int TB_POLLS = 1024;
`endif

  mem_txn_fsm #(.TIMEOUT_POLLS(TB_POLLS)) dut (
    .clk(clk), .rst(rst), .ena(ena), .r_w(r_w),
    .address_valid(address_valid), .address(address),
    .length_valid(length_valid), .length(length),
    .in_fsm_data(in_fsm_data), .in_fsm_valid(in_fsm_valid), .in_fsm_ready(in_fsm_ready),
    .out_fsm_data(out_fsm_data), .out_fsm_valid(out_fsm_valid), .out_fsm_ready(out_fsm_ready),
    .txn_done(txn_done), .err(err),
    .qspi_start(qspi_start), .qspi_cmd(qspi_cmd), .qspi_addr_en(qspi_addr_en),
    .qspi_addr(qspi_addr), .qspi_dummy(qspi_dummy), .qspi_rw(qspi_rw), .qspi_len(qspi_len),
    .qspi_done(qspi_done),
    .qspi_tx_data(qspi_tx_data), .qspi_tx_valid(qspi_tx_valid), .qspi_tx_ready(qspi_tx_ready),
    .qspi_rx_data(qspi_rx_data), .qspi_rx_valid(qspi_rx_valid), .qspi_rx_ready(qspi_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r_w;
    logic [23:0] addr;
    logic [8:0]  len;
    int          nwip;
    bit          toggle;
    int          exp_starts;
    int          exp_low;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  int phase, rem, idx, widx, wt, wip_left, low_cycles, mirror_checks;
  bit toggle_mode;
  logic [7:0]  cmd_log[$];
  logic [8:0]  len_log[$];
  logic [23:0] addr_log[$];
  logic [3:0]  dmy_log[$];
  logic        aen_log[$];
  logic        rw_log[$];
  logic [7:0]  rx_seen[$];
  logic [7:0]  tx_seen[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] wr_byte(input int i);
    return 8'hA1 + 8'(i * 17);
  endfunction

  function automatic logic [7:0] exp_cmd(input logic rw, input int i);
    if (rw) return 8'h6B;
    if (i == 0) return 8'h06;
    if (i == 1) return 8'h32;
    return 8'h05;
  endfunction

  task automatic clear_logs();
    cmd_log.delete(); len_log.delete(); addr_log.delete(); dmy_log.delete();
    aen_log.delete(); rw_log.delete(); rx_seen.delete(); tx_seen.delete();
    phase = 0; rem = 0; idx = 0; widx = 0; wt = 0; low_cycles = 0; mirror_checks = 0;
  endtask

  // One clock of the QSPI responder, acting at the falling edge.
  task automatic cycle();
    @(negedge clk);
    qspi_done = 1'b0; qspi_rx_valid = 1'b0; qspi_tx_ready = 1'b0; in_fsm_valid = 1'b0;
    in_fsm_ready = toggle_mode ? ~in_fsm_ready : 1'b1;
    if (!txn_done) low_cycles++;
    if (qspi_start) begin
      cmd_log.push_back(qspi_cmd); len_log.push_back(qspi_len); addr_log.push_back(qspi_addr);
      dmy_log.push_back(qspi_dummy); aen_log.push_back(qspi_addr_en); rw_log.push_back(qspi_rw);
      case (qspi_cmd)
        8'h6B: begin phase = 1; rem = int'(qspi_len); idx = 0; end
        8'h06: begin phase = 2; wt = 2; end
        8'h32: begin phase = 3; rem = int'(qspi_len); widx = 0; end
        8'h05: begin phase = 4; wt = 2; end
        default: phase = 0;
      endcase
    end
    case (phase)
      1: if (rem > 0) begin qspi_rx_valid = 1'b1; qspi_rx_data = 8'(idx); end
      2: begin wt--; if (wt == 0) begin qspi_done = 1'b1; phase = 0; end end
      3: if (rem > 0) begin
           qspi_tx_ready = 1'b1; in_fsm_valid = 1'b1; in_fsm_data = wr_byte(widx);
         end else begin
           qspi_done = 1'b1; phase = 0;
         end
      4: begin
           wt--;
           if (wt == 0) begin
             qspi_rx_valid = 1'b1;
             qspi_rx_data  = (wip_left > 0) ? 8'h01 : 8'h00;
             if (wip_left > 0) wip_left--;
             qspi_done = 1'b1; phase = 0;
           end
         end
      default: ;
    endcase
    #1;
    if (phase == 1 && toggle_mode && mirror_checks < 8) begin
      mirror_checks++;
      chk("rx_ready_mirror", qspi_rx_ready, in_fsm_ready);
    end
    if (phase == 1 && rem == 1 && qspi_rx_valid && qspi_rx_ready) qspi_done = 1'b1;
    if (out_fsm_valid && in_fsm_ready) rx_seen.push_back(out_fsm_data);
    if (phase == 1 && qspi_rx_valid && qspi_rx_ready) begin
      idx++; rem--;
      if (rem == 0) phase = 0;
    end
    if (in_fsm_valid && out_fsm_ready) widx++;
    if (qspi_tx_valid && qspi_tx_ready) begin tx_seen.push_back(qspi_tx_data); rem--; end
  endtask

  task automatic start_txn(input logic rw, input logic [23:0] a, input logic [8:0] n);
    @(negedge clk);
    in_fsm_ready = 1'b1;
    ena = 1'b1; r_w = rw;
    address = a; address_valid = 1'b1;
    length = n; length_valid = 1'b1;
    @(negedge clk);
    address_valid = 1'b0; length_valid = 1'b0;
  endtask

  task automatic run_to_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      cycle();
      if (low_cycles > 0 && txn_done) begin ok = 1'b1; break; end
    end
    chk({name, "_completes"}, ok, 1'b1);
    ena = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txn_done"}, txn_done, 1'b1);
    chk({tag, "_out_fsm_ready"}, out_fsm_ready, 1'b1);
    chk({tag, "_qspi_start"}, qspi_start, 1'b0);
    chk({tag, "_qspi_cmd"}, qspi_cmd, 8'h00);
    chk({tag, "_qspi_len"}, qspi_len, 9'd0);
    chk({tag, "_qspi_addr"}, qspi_addr, 24'd0);
    chk({tag, "_qspi_addr_en"}, qspi_addr_en, 1'b0);
    chk({tag, "_tx_valid"}, qspi_tx_valid, 1'b0);
    chk({tag, "_rx_ready"}, qspi_rx_ready, 1'b0);
    chk({tag, "_out_valid"}, out_fsm_valid, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    int bad;
    string t;
    vecs[0] = '{1'b1, 24'h012345, 9'd16,  0, 1'b0, 1, 17};
    vecs[1] = '{1'b0, 24'h000100, 9'd4,   2, 1'b0, 5, 14};
    vecs[2] = '{1'b1, 24'hABCDEF, 9'd32,  0, 1'b1, 1, 65};
    vecs[3] = '{1'b1, 24'h000010, 9'd1,   0, 1'b0, 1, 2};
    vecs[4] = '{1'b0, 24'h000020, 9'd1,   0, 1'b0, 3, 7};
    vecs[5] = '{1'b1, 24'h000000, 9'd256, 0, 1'b0, 1, 257};
    vecs[6] = '{1'b0, 24'h0000FE, 9'd4,   0, 1'b0, 3, 10};

    rst = 1'b1; ena = 1'b0; r_w = 1'b0; address_valid = 1'b0; address = '0;
    length_valid = 1'b0; length = '0; in_fsm_data = '0; in_fsm_valid = 1'b0;
    in_fsm_ready = 1'b1; qspi_done = 1'b0; qspi_tx_ready = 1'b0; qspi_rx_data = '0;
    qspi_rx_valid = 1'b0; toggle_mode = 1'b0; wip_left = 0;
    clear_logs();
    repeat (3) @(negedge clk);
    #1 chk_reset_vals("in_reset");
    rst = 1'b0;
    @(negedge clk);
    #1 chk_reset_vals("after_reset");

    for (int v = 0; v < 7; v++) begin
      clear_logs();
      wip_left = vecs[v].nwip;
      start_txn(vecs[v].r_w, vecs[v].addr, vecs[v].len);
      toggle_mode = vecs[v].toggle;
      run_to_idle($sformatf("v%0d", v), 2000);
      toggle_mode = 1'b0;
      t = $sformatf("v%0d_", v);
      chk({t, "starts"}, cmd_log.size(), vecs[v].exp_starts);
      for (int i = 0; i < cmd_log.size(); i++)
        chk($sformatf("%scmd%0d", t, i), cmd_log[i], exp_cmd(vecs[v].r_w, i));
      chk({t, "done_low_cycles"}, low_cycles, vecs[v].exp_low);
      if (vecs[v].r_w) begin
        if (cmd_log.size() > 0) begin
          chk({t, "rd_len"}, len_log[0], vecs[v].len);
          chk({t, "rd_dummy"}, dmy_log[0], 4'd8);
          chk({t, "rd_addr"}, addr_log[0], vecs[v].addr);
          chk({t, "rd_addr_en"}, aen_log[0], 1'b1);
          chk({t, "rd_rw"}, rw_log[0], 1'b1);
        end
        chk({t, "rx_count"}, rx_seen.size(), vecs[v].len);
        bad = 0;
        for (int i = 0; i < rx_seen.size(); i++) if (rx_seen[i] !== 8'(i)) bad++;
        chk({t, "rx_order_errors"}, bad, 0);
      end else begin
        if (cmd_log.size() > 2) begin
          chk({t, "wren_len"}, len_log[0], 9'd0);
          chk({t, "wren_addr_en"}, aen_log[0], 1'b0);
          chk({t, "pp_len"}, len_log[1], vecs[v].len);
          chk({t, "pp_addr"}, addr_log[1], vecs[v].addr);
          chk({t, "pp_addr_en"}, aen_log[1], 1'b1);
          chk({t, "pp_rw"}, rw_log[1], 1'b0);
          chk({t, "rdsr_len"}, len_log[cmd_log.size()-1], 9'd1);
          chk({t, "rdsr_rw"}, rw_log[cmd_log.size()-1], 1'b1);
        end
        chk({t, "tx_count"}, tx_seen.size(), vecs[v].len);
        bad = 0;
        for (int i = 0; i < tx_seen.size(); i++) if (tx_seen[i] !== wr_byte(i)) bad++;
        chk({t, "tx_data_errors"}, bad, 0);
      end
      chk({t, "txn_done_end"}, txn_done, 1'b1);
      chk({t, "out_ready_end"}, out_fsm_ready, 1'b1);
      chk({t, "err_end"}, err, 1'b0);
    end

    // Address and length strobes in different cycles, ena already high.
    clear_logs();
    ena = 1'b1; r_w = 1'b1; address = 24'h000400; length = 9'd8;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      address_valid = (c == 2);
      length_valid  = (c == 5);
      #1;
      chk($sformatf("split_c%0d_no_start", c), qspi_start, 1'b0);
      chk($sformatf("split_c%0d_idle", c), txn_done, 1'b1);
    end
    address_valid = 1'b0; length_valid = 1'b0;
    run_to_idle("split", 500);
    chk("split_starts", cmd_log.size(), 1);
    if (cmd_log.size() > 0) begin
      chk("split_len", len_log[0], 9'd8);
      chk("split_addr", addr_log[0], 24'h000400);
    end
    chk("split_rx_count", rx_seen.size(), 8);

    // Zero-length transaction: no command, txn_done dips for a single cycle.
    clear_logs();
    start_txn(1'b0, 24'h000500, 9'd0);
    run_to_idle("len0", 100);
    chk("len0_starts", cmd_log.size(), 0);
    chk("len0_low_cycles", low_cycles, 1);

    // Reset in the middle of a page program after two of four bytes.
    clear_logs();
    wip_left = 0;
    start_txn(1'b0, 24'h000200, 9'd4);
    bad = 1;
    for (int c = 0; c < 100; c++) begin
      cycle();
      if (tx_seen.size() == 2) begin bad = 0; break; end
    end
    chk("midreset_reached_2_bytes", bad, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midreset");
    @(negedge clk);
    ena = 1'b0; in_fsm_valid = 1'b0; qspi_tx_ready = 1'b0; qspi_done = 1'b0;
    rst = 1'b0;
    clear_logs();
    repeat (4) cycle();
    chk("midreset_no_start", cmd_log.size(), 0);
    chk("midreset_idle", txn_done, 1'b1);
    clear_logs();
    start_txn(1'b1, 24'h000300, 9'd4);
    run_to_idle("post_reset_read", 200);
    chk("post_reset_starts", cmd_log.size(), 1);
    chk("post_reset_rx_count", rx_seen.size(), 4);
    bad = 0;
    for (int i = 0; i < rx_seen.size(); i++) if (rx_seen[i] !== 8'(i)) bad++;
    chk("post_reset_rx_order", bad, 0);

`ifdef MEM_TXN_TIMEOUT_EN
    // WIP never clears: polling stops after four RDSR commands with err set.
    clear_logs();
    wip_left = 1000;
    start_txn(1'b0, 24'h000600, 9'd2);
    run_to_idle("timeout", 500);
    chk("timeout_starts", cmd_log.size(), 6);
    chk("timeout_err", err, 1'b1);
    chk("timeout_idle", txn_done, 1'b1);
    wip_left = 0;
`else
    chk("final_err_tied_low", err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
